// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// The optional bad-PC fault feature is enabled by defining IFETCH_FAULT_EN.
package ifetch_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int DEFAULT_DEPTH = 2;

    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/ifetch_fifo.sv
// Shift-register prefetch FIFO: entry 0 is always the head, so the head is a plain register.
// Clear wins over push and pop.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    input  fetch_entry_t               wdata_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] writeIdx;

    // On a simultaneous pop the new word lands one slot lower, behind the shifted entries.
    always_comb begin
        mem_d    = mem_q;
        count_d  = count_q;
        writeIdx = pop_i ? (count_q - CNT_W'(1)) : count_q;
        if (clear_i) begin
            count_d = '0;
        end else begin
            if (pop_i) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem_d[i] = mem_q[i+1];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (push_i && (writeIdx == CNT_W'(i))) begin
                    mem_d[i] = wdata_i;
                end
            end
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[0];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: fetch PC, redirect handling and prefetch FIFO hand-off to decode.
// Define IFETCH_FAULT_EN to enable bad-PC detection, the HALT state and the fault output.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int          ADDR_W   = 7,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = DEFAULT_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_rd,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        fault
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    state_e           state_q;
    state_e           state_d;
    logic [31:0]      pc_q;
    logic [31:0]      pc_d;
    logic [31:0]      pcInc;
    logic             push;
    logic             pop;
    logic             pcBad;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [CNT_W-1:0] fifoCount;
    fetch_entry_t     fifoHead;
    fetch_entry_t     fifoWdata;

`ifdef IFETCH_FAULT_EN
    function automatic logic badPc(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:ADDR_W] != '0);
    endfunction

    assign pcInc = pc_q + 32'd4;
    assign fault = (state_q == HALT);
`else
    localparam logic [31:0] WRAP_MASK = (32'd1 << ADDR_W) - 32'd1;

    assign pcInc = (pc_q + 32'd4) & WRAP_MASK;
    assign fault = 1'b0;
`endif

    assign pop       = (fifoCount != '0) && inst_ready;
    assign fifoWdata = '{pc: pc_q, inst: imem_rd};

    // A redirect to a bad target leaves the state alone, so from RUN the fault shows one cycle later.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        pcBad   = 1'b0;
`ifdef IFETCH_FAULT_EN
        pcBad   = badPc(pc_q);
`endif
        if (redirect_valid) begin
            pc_d = redirect_pc;
`ifdef IFETCH_FAULT_EN
            state_d = badPc(redirect_pc) ? state_q : RUN;
`endif
        end else if (state_q == RUN) begin
            if (pcBad) begin
                state_d = HALT;
            end else if (!fifoFull || pop) begin
                push = 1'b1;
                pc_d = pcInc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (redirect_valid),
        .wdata_i (fifoWdata),
        .head_o  (fifoHead),
        .count_o (fifoCount),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    assign imem_a     = pc_q;
    assign inst_valid = !fifoEmpty;
    assign inst       = fifoHead.inst;
    assign inst_pc    = fifoHead.pc;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl; fault-path checks follow IFETCH_FAULT_EN.
// Inputs change 1ns after the rising edge, the monitor samples on the falling edge.
module tb_ifetch_ctrl;
    import ifetch_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        fault;

    logic [31:0]  mem [32];
    fetch_entry_t expQ [$];
    fetch_entry_t expEntry;
    int           errors = 0;
    int           checks = 0;

    ifetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_a         (imem_a),
        .imem_rd        (imem_rd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .fault          (fault)
    );

    assign imem_rd = mem[imem_a[6:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = 32'hA000_0000 + 32'(i);
        end
        mem[0] = 32'h0050_0113;
        mem[1] = 32'h00c0_0193;
        mem[2] = 32'hff71_8393;
        mem[3] = 32'h0023_e233;
    end

    // Every accepted handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && inst_valid && inst_ready) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected: got pc=%h inst=%h, required no transfer", inst_pc, inst);
            end else begin
                expEntry = expQ.pop_front();
                if (inst_pc !== expEntry.pc || inst !== expEntry.inst) begin
                    errors++;
                    $display("[TB] FAIL sb_transfer: got pc=%h inst=%h, required pc=%h inst=%h",
                             inst_pc, inst, expEntry.pc, expEntry.inst);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rpc);
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic pushExp(input logic [31:0] pc, input logic [31:0] word);
        expQ.push_back('{pc: pc, inst: word});
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between clock edges, so only an asynchronous reset shows the values in time.
    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        #3;
        checkOutput("rst_valid", 32'(inst_valid), 32'h0);
        checkOutput("rst_inst", inst, 32'h0);
        checkOutput("rst_inst_pc", inst_pc, 32'h0);
        checkOutput("rst_fault", 32'(fault), 32'h0);
        checkOutput("rst_imem_a", imem_a, 32'h0);
        checkOutput("sb_drained", 32'(expQ.size()), 32'h0);
        cycle();
    endtask

    task automatic releaseReset(input logic rdy, input logic rv, input logic [31:0] rpc);
        applyStimulus(rdy, rv, rpc);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        doReset();

        $display("[TB] streaming from reset");
        pushExp(32'h0, 32'h0050_0113);
        pushExp(32'h4, 32'h00c0_0193);
        pushExp(32'h8, 32'hff71_8393);
        releaseReset(1'b1, 1'b0, 32'h0);
        cycle();
        checkOutput("t1_valid", 32'(inst_valid), 32'h1);
        checkOutput("t1_inst_pc", inst_pc, 32'h0);
        checkOutput("t1_inst", inst, 32'h0050_0113);
        checkOutput("t1_imem_a", imem_a, 32'h4);
        repeat (3) cycle();
        doReset();

        $display("[TB] back-pressure until full");
        pushExp(32'h0, 32'h0050_0113);
        pushExp(32'h4, 32'h00c0_0193);
        pushExp(32'h8, 32'hff71_8393);
        releaseReset(1'b0, 1'b0, 32'h0);
        repeat (5) cycle();
        checkOutput("t2_imem_a_hold", imem_a, 32'h8);
        checkOutput("t2_valid", 32'(inst_valid), 32'h1);
        checkOutput("t2_head_pc", inst_pc, 32'h0);
        checkOutput("t2_head_inst", inst, 32'h0050_0113);
        applyStimulus(1'b1, 1'b0, 32'h0);
        repeat (3) cycle();
        doReset();

        $display("[TB] redirect while full");
        pushExp(32'h0, 32'h0050_0113);
        pushExp(32'hC, 32'h0023_e233);
        releaseReset(1'b0, 1'b0, 32'h0);
        repeat (3) cycle();
        checkOutput("t3_imem_a_full", imem_a, 32'h8);
        applyStimulus(1'b1, 1'b1, 32'hC);
        cycle();
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("t3_bubble_valid", 32'(inst_valid), 32'h0);
        checkOutput("t3_imem_a_target", imem_a, 32'hC);
        cycle();
        checkOutput("t3_target_valid", 32'(inst_valid), 32'h1);
        checkOutput("t3_target_pc", inst_pc, 32'hC);
        cycle();
        doReset();

`ifdef IFETCH_FAULT_EN
        $display("[TB] misaligned redirect with fault detection");
        pushExp(32'h4, 32'h00c0_0193);
        releaseReset(1'b0, 1'b1, 32'h6);
        cycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t4_imem_a_bad", imem_a, 32'h6);
        checkOutput("t4_fault_early", 32'(fault), 32'h0);
        checkOutput("t4_valid_c1", 32'(inst_valid), 32'h0);
        cycle();
        checkOutput("t4_fault_set", 32'(fault), 32'h1);
        checkOutput("t4_valid_halt", 32'(inst_valid), 32'h0);
        checkOutput("t4_imem_a_halt", imem_a, 32'h6);
        applyStimulus(1'b0, 1'b1, 32'h100);
        cycle();
        checkOutput("t4_fault_bad_redirect", 32'(fault), 32'h1);
        checkOutput("t4_imem_a_range", imem_a, 32'h100);
        applyStimulus(1'b1, 1'b1, 32'h4);
        cycle();
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("t4_fault_cleared", 32'(fault), 32'h0);
        checkOutput("t4_imem_a_good", imem_a, 32'h4);
        checkOutput("t4_valid_bubble", 32'(inst_valid), 32'h0);
        cycle();
        checkOutput("t4_valid_resume", 32'(inst_valid), 32'h1);
        checkOutput("t4_inst_resume", inst, 32'h00c0_0193);
        cycle();
        doReset();
`else
        $display("[TB] misaligned redirect without fault detection");
        pushExp(32'h6, 32'h00c0_0193);
        releaseReset(1'b0, 1'b1, 32'h6);
        cycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t4_imem_a_mis", imem_a, 32'h6);
        checkOutput("t4_fault_c1", 32'(fault), 32'h0);
        checkOutput("t4_valid_c1", 32'(inst_valid), 32'h0);
        cycle();
        checkOutput("t4_fault_c2", 32'(fault), 32'h0);
        checkOutput("t4_valid_c2", 32'(inst_valid), 32'h1);
        checkOutput("t4_head_pc", inst_pc, 32'h6);
        checkOutput("t4_imem_a_next", imem_a, 32'hA);
        applyStimulus(1'b1, 1'b0, 32'h0);
        cycle();
        doReset();
`endif

        $display("[TB] sequential fetch to the top of memory");
        pushExp(32'h70, 32'hA000_001C);
        pushExp(32'h74, 32'hA000_001D);
        pushExp(32'h78, 32'hA000_001E);
        pushExp(32'h7C, 32'hA000_001F);
`ifndef IFETCH_FAULT_EN
        pushExp(32'h0, 32'h0050_0113);
`endif
        releaseReset(1'b1, 1'b1, 32'h70);
        cycle();
        applyStimulus(1'b1, 1'b0, 32'h0);
        repeat (4) cycle();
        checkOutput("t5_last_pc", inst_pc, 32'h7C);
        checkOutput("t5_fault_c5", 32'(fault), 32'h0);
`ifdef IFETCH_FAULT_EN
        checkOutput("t5_imem_a_end", imem_a, 32'h80);
        cycle();
        checkOutput("t5_fault_range", 32'(fault), 32'h1);
        checkOutput("t5_valid_halt", 32'(inst_valid), 32'h0);
        checkOutput("t5_imem_a_halt", imem_a, 32'h80);
`else
        checkOutput("t5_imem_a_wrap", imem_a, 32'h0);
        cycle();
        checkOutput("t5_wrap_pc", inst_pc, 32'h0);
        checkOutput("t5_wrap_inst", inst, 32'h0050_0113);
        checkOutput("t5_imem_a_after", imem_a, 32'h4);
`endif
        cycle();
        doReset();

        $display("[TB] restart after mid-stream reset");
        pushExp(32'h0, 32'h0050_0113);
        pushExp(32'h4, 32'h00c0_0193);
        releaseReset(1'b1, 1'b0, 32'h0);
        repeat (3) cycle();
        doReset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
